// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the integer register file and its scoreboard.
// Pure declarations; no logic, no latency, no backpressure.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on writeback or flush.
// Busy lookup is combinational; updates land at the next edge; never stalls its producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 run_i,
    input  logic [NUM_RD*AW-1:0] rd_addr_i,
    input  logic [NUM_RD-1:0]    rd_byp_i,
    input  logic                 wr_en_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic                 issue_en_i,
    input  logic [AW-1:0]        issue_addr_i,
    input  logic                 flush_i,
    output logic [NUM_RD-1:0]    rd_busy_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Issue is applied after the writeback clear so a newer producer keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        if (flush_i) begin
            pending_d = '0;
        end else begin
            if (wr_en_i) begin
                pending_d[wr_addr_i] = 1'b0;
            end
            if (issue_en_i) begin
                pending_d[issue_addr_i] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else if (run_i) begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rd_busy_o = '1;
        for (int k = 0; k < NUM_RD; k++) begin
            if (!run_i) begin
                rd_busy_o[k] = 1'b1;
            end else if (rd_addr_i[k*AW +: AW] == '0 || rd_byp_i[k]) begin
                rd_busy_o[k] = 1'b0;
            end else begin
                rd_busy_o[k] = pending_q[rd_addr_i[k*AW +: AW]];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with combinational read ports, one write port, optional bypass and a clear sweep after reset.
// Reads 0 cycles, writes 1 cycle; no backpressure, ready_o only gates the post-reset sweep.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     ready_o,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     issue_en_i,
    input  logic [AW-1:0]            issue_addr_i,
    input  logic                     flush_i
);

    rf_state_e           state_q;
    rf_state_e           state_d;
    logic [AW-1:0]       idx_q;
    logic                run;
    logic                mem_we;
    logic [AW-1:0]       mem_wa;
    logic [DATA_W-1:0]   mem_wd;
    logic [NUM_RD-1:0]   rd_byp;
    logic [DATA_W-1:0]   mem [NUM_REGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && idx_q == AW'(NUM_REGS - 1)) begin
            state_d = RUN;
        end
    end

    // The sweep borrows the single write port, so no wide parallel reset is needed.
    always_comb begin
        run     = (state_q == RUN);
        ready_o = run;
        if (state_q == INIT) begin
            mem_we = !rst_i;
            mem_wa = idx_q;
            mem_wd = '0;
        end else begin
            mem_we = wr_en_i && (wr_addr_i != '0);
            mem_wa = wr_addr_i;
            mem_wd = wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= AW'(1);
        end else if (state_q == INIT) begin
            idx_q <= idx_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        rd_byp = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_byp[k] = (BYPASS != 0) && run && wr_en_i && (wr_addr_i != '0)
                        && (wr_addr_i == rd_addr_i[k*AW +: AW]);
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (run && rd_addr_i[k*AW +: AW] != '0) begin
                rd_data_o[k*DATA_W +: DATA_W] = rd_byp[k] ? wr_data_i
                                                          : mem[rd_addr_i[k*AW +: AW]];
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .run_i        (run),
        .rd_addr_i    (rd_addr_i),
        .rd_byp_i     (rd_byp),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .rd_busy_o    (rd_busy_o)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a BYPASS=0 and a BYPASS=1 instance share stimulus and one reference model.
module tb_regfile_sb;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i;
    logic [NRD*AW-1:0]  rd_addr;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DW-1:0]      wr_data;
    logic               issue_en;
    logic [AW-1:0]      issue_addr;
    logic               flush;

    logic               rdy0, rdy1;
    logic [NRD*DW-1:0]  rdd0, rdd1;
    logic [NRD-1:0]     rdb0, rdb1;

    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .ready_o(rdy0),
        .rd_addr_i(rd_addr), .rd_data_o(rdd0), .rd_busy_o(rdb0),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush)
    );

    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .ready_o(rdy1),
        .rd_addr_i(rd_addr), .rd_data_o(rdd1), .rd_busy_o(rdb1),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: register values, pending flags, and edges since reset release.
    logic [DW-1:0] m_mem [NR];
    bit            m_pend [NR];
    bit            m_run  = 1'b0;
    int            m_cnt  = 0;
    bit            chk_en = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst_i) begin
            m_run  = 1'b0;
            m_cnt  = 0;
            chk_en = 1'b1;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (!m_run) begin
            m_cnt++;
            if (m_cnt == NR - 1) begin
                m_run = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else begin
            if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
            if (flush) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
            end else begin
                if (wr_en)    m_pend[wr_addr]    = 1'b0;
                if (issue_en) m_pend[issue_addr] = 1'b1;
            end
            m_pend[0] = 1'b0;
        end
    end

    function automatic logic [DW:0] exp_rd(input bit byp, input logic [AW-1:0] a);
        if (!m_run)                              return {1'b1, {DW{1'b0}}};
        if (a == 0)                              return '0;
        if (byp && wr_en && wr_addr == a)        return {1'b0, wr_data};
        return {m_pend[a], m_mem[a]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("ready nobyp", 64'(rdy0), 64'(m_run));
            chk("ready byp",   64'(rdy1), 64'(m_run));
            for (int k = 0; k < NRD; k++) begin
                logic [DW:0] e0, e1;
                e0 = exp_rd(1'b0, rd_addr[k*AW +: AW]);
                e1 = exp_rd(1'b1, rd_addr[k*AW +: AW]);
                chk($sformatf("nobyp p%0d data", k), 64'(rdd0[k*DW +: DW]), 64'(e0[DW-1:0]));
                chk($sformatf("nobyp p%0d busy", k), 64'(rdb0[k]),          64'(e0[DW]));
                chk($sformatf("byp p%0d data", k),   64'(rdd1[k*DW +: DW]), 64'(e1[DW-1:0]));
                chk($sformatf("byp p%0d busy", k),   64'(rdb1[k]),          64'(e1[DW]));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
    endtask

    function automatic logic [AW-1:0] raddr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        rst_i = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
        idle();

        // Reset pulse for 3 edges, then the sweep.
        repeat (3) @(posedge clk);
        #1;
        rst_i   = 1'b0;
        rd_addr = {AW'(5), AW'(5)};
        @(negedge clk);
        chk("reset ready", 64'(rdy0), 64'd0);
        chk("reset busy",  64'(rdb1), 64'd3);
        chk("reset data",  64'(rdd1), 64'd0);
        for (int e = 1; e <= NR - 1; e++) begin
            nxt();
            if (e < NR - 1) chk($sformatf("sweep ready e%0d", e), 64'(rdy0), 64'd0);
            else            chk("ready after sweep", 64'(rdy1), 64'd1);
            if (e == 10) begin
                chk("sweep r5 data", 64'(rdd1[DW-1:0]), 64'd0);
                chk("sweep r5 busy", 64'(rdb0[0]), 64'd1);
            end
        end
        chk("model run after sweep", 64'(m_run), 64'd1);

        for (int a = 0; a < NR; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            @(negedge clk);
            chk($sformatf("clear r%0d", a), {rdd0, 28'd0, rdb0, rdb1}, 64'd0);
            nxt();
        end

        // Write r7, both ports read r7.
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF; rd_addr = {AW'(7), AW'(7)};
        @(negedge clk);
        chk("r7 same cycle nobyp", 64'(rdd0[DW-1:0]), 64'd0);
        chk("r7 same cycle byp",   64'(rdd1[DW +: DW]), 64'hDEADBEEF);
        nxt(); idle();
        @(negedge clk);
        chk("r7 next cycle", {rdd0[DW +: DW], rdd0[DW-1:0]}, 64'hDEADBEEF_DEADBEEF);

        nxt();
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; rd_addr = {AW'(0), AW'(0)};
        @(negedge clk);
        chk("r0 write bypass", 64'(rdd1[DW-1:0]), 64'd0);
        nxt(); idle();
        @(negedge clk);
        chk("r0 write stored", 64'(rdd0[DW +: DW]), 64'd0);

        nxt();
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hA5A5A5A5; rd_addr = {AW'(3), AW'(0)};
        @(negedge clk);
        chk("r3 bypass data", 64'(rdd1[DW +: DW]), 64'hA5A5A5A5);
        chk("r3 bypass busy", 64'(rdb1[1]), 64'd0);

        // Scoreboard: issue r9 at t, write at t+4.
        nxt(); idle();
        issue_en = 1'b1; issue_addr = 9; rd_addr = {AW'(9), AW'(9)};
        @(negedge clk);
        chk("r9 busy at t", 64'(rdb0[0]), 64'd0);
        nxt(); idle();
        @(negedge clk);
        chk("r9 busy t+1", {62'd0, rdb0[0], rdb1[0]}, 64'd3);
        nxt(); nxt(); nxt();
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99;
        @(negedge clk);
        chk("r9 busy t+4 byp",   64'(rdb1[1]), 64'd0);
        chk("r9 busy t+4 nobyp", 64'(rdb0[1]), 64'd1);
        nxt(); idle();
        @(negedge clk);
        chk("r9 busy t+5", {62'd0, rdb0[0], rdb1[0]}, 64'd0);
        chk("r9 data t+5", 64'(rdd0[DW-1:0]), 64'h99);
        nxt();
        issue_en = 1'b1; issue_addr = 9; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h77;
        nxt(); idle();
        @(negedge clk);
        chk("r9 issue+write busy", {62'd0, rdb0[0], rdb1[0]}, 64'd3);

        // Flush with a same-cycle issue.
        for (int r = 2; r <= 6; r += 2) begin
            nxt();
            issue_en = 1'b1; issue_addr = AW'(r);
        end
        nxt(); idle();
        flush = 1'b1; issue_en = 1'b1; issue_addr = 8; rd_addr = {AW'(4), AW'(2)};
        @(negedge clk);
        chk("pre-flush busy r2 r4", 64'(rdb0), 64'd3);
        nxt(); idle();
        @(negedge clk);
        chk("flush busy r2 r4", {62'd0, rdb0, rdb1}, 64'd0);
        nxt();
        rd_addr = {AW'(8), AW'(6)};
        @(negedge clk);
        chk("flush busy r6 r8", {62'd0, rdb0, rdb1}, 64'd0);

        // Mid-run reset with r9 pending and r7 holding data.
        nxt();
        issue_en = 1'b1; issue_addr = 9;
        nxt(); idle();
        rst_i = 1'b1; rd_addr = {AW'(9), AW'(7)};
        @(negedge clk);
        chk("pre-reset r7", 64'(rdd0[DW-1:0]), 64'hDEADBEEF);
        chk("pre-reset r9 busy", 64'(rdb1[1]), 64'd1);
        nxt();
        rst_i = 1'b0;
        chk("midreset ready", 64'(rdy1), 64'd0);
        chk("midreset busy", 64'(rdb0), 64'd3);
        repeat (NR - 1) nxt();
        chk("resweep ready", 64'(rdy0), 64'd1);
        chk("resweep r7", 64'(rdd1[DW-1:0]), 64'd0);
        chk("resweep r9 busy", {62'd0, rdb0[1], rdb1[1]}, 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            nxt();
            rst_i      = ($urandom_range(0, 999) == 0);
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_addr    = raddr();
            wr_data    = $urandom;
            issue_en   = ($urandom_range(0, 2) != 0);
            issue_addr = raddr();
            flush      = ($urandom_range(0, 19) == 0);
            rd_addr    = {raddr(), raddr()};
        end
        nxt();
        rst_i = 1'b0; idle();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a per-register pending-write scoreboard for the pipelined core. It provides NUM_RD combinational read ports and one write port, with optional write-to-read bypass and a hardwired zero register. A sequential clear sweep after reset replaces wide parallel reset. The decode stage reads operands and busy flags from it; the writeback stage writes results into it.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers; power of two, ≥4
- NUM_RD, 2, number of read ports, 1..4
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads see stored value only
- AW, $clog2(NUM_REGS), address width (derived; do not override)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- ready_o  out  1  1 = clear sweep done, block accepts writes and issues
- rd_addr_i  in  NUM_RD×AW  read addresses
- rd_data_o  out  NUM_RD×DATA_W  read data, combinational
- rd_busy_o  out  NUM_RD  1 = addressed register has an outstanding producer
- wr_en_i  in  1  writeback enable
- wr_addr_i  in  AW  writeback address
- wr_data_i  in  DATA_W  writeback data
- issue_en_i  in  1  marks issue_addr_i pending (new in-flight producer)
- issue_addr_i  in  AW  destination of the issued instruction
- flush_i  in  1  clears all pending bits (pipeline flush)

## Operation
- Storage holds registers 1..NUM_REGS-1. Register 0 always reads 0 and is never busy. Writes and issues to address 0 are ignored.
- State machine:
  - INIT: entered while rst_i=1.
  - In INIT, clear index idx is held at 1 while rst_i=1. Each cycle after release, 0 is written to register idx and idx increments.
  - After writing NUM_REGS-1, the FSM moves to RUN.
  - RUN persists until rst_i.
- In INIT:
  - ready_o=0, all rd_data_o=0, all rd_busy_o=1.
  - wr_en_i, issue_en_i and flush_i are ignored.
- In RUN:
  - wr_en_i with addr≠0 writes wr_data_i at the edge.
  - The scoreboard updates with this priority, highest first:
    1. flush_i: all pending bits cleared; issue_en_i in the same cycle is ignored.
    2. issue_en_i: pending[issue_addr_i] set.
    3. wr_en_i: pending[wr_addr_i] cleared.
  - Issue and write to the same register in the same cycle: the register stays pending, because the newer producer wins. The data is still written.
- Read port k, in RUN:
  - rd_addr=0 → data 0, busy 0.
  - BYPASS=1 and wr_en_i and wr_addr_i=rd_addr≠0 → data=wr_data_i, busy=0.
  - Otherwise → data=stored value, busy=pending[rd_addr].
- Pending bits are cleared while rst_i=1.

## Timing
- Reset values: ready_o=0, rd_data_o=0, rd_busy_o=all 1, pending=0, state=INIT.
- Clear sweep: ready_o rises NUM_REGS-1 cycles after the first cycle with rst_i=0. For defaults, that is the 31st edge after release.
- rst_i asserted mid-sweep or in RUN: the next edge returns the FSM to INIT with idx=1 and pending cleared. Register contents are undefined until the sweep completes.
- Read latency is 0; the read path is combinational from rd_addr_i, wr_* and state.
- Write latency is 1; with BYPASS=0, the value is readable in the cycle after wr_en_i.
- Issue: busy is visible to reads in the cycle after issue_en_i (no issue bypass).
- Flush: all busy flags are 0 in the cycle after flush_i, except a same-cycle write that is bypassed, which is already 0.
- Simultaneous writes on a read port and the write port to the same address are covered by the bypass rule; there are no structural hazards.

## Structure
- Shared package regfile_pkg holds:
  - rf_state_e: INIT, RUN
  - the default constants RF_DATA_W=32 and RF_NUM_REGS=32
- Natural sub-module: regfile_scoreboard, which owns the pending vector, the priority logic and the busy lookup per read port.
- The storage array, clear FSM and read muxes stay in regfile_sb.

## Test plan
- Reset/sweep: pulse rst_i for 3 cycles, then release.
  - ready_o stays 0 for 30 edges and is 1 after the 31st.
  - During the sweep, reads of r5 return 0 with busy=1.
  - After the sweep, all registers read 0 with busy=0.
- Write/read, BYPASS=0: write r7=0xDEADBEEF.
  - Same cycle: rd_data for r7 is 0.
  - Next cycle: 0xDEADBEEF on both ports.
  - Write r0=0x1234 → r0 still reads 0.
- Bypass, BYPASS=1: write r3=0xA5A5A5A5 while port1 reads r3.
  - Same cycle: port1 shows 0xA5A5A5A5 with busy=0.
- Scoreboard: issue r9 at cycle t.
  - busy=1 from t+1.
  - Write r9 at t+4 → busy=0 on bypass at t+4 and stored at t+5.
  - Issue and write r9 together → busy remains 1.
- Flush: pend r2, r4 and r6; assert flush_i together with issue r8.
  - Next cycle: all four read busy=0.
- Mid-run reset: assert rst_i while r9 is pending and r7=0xDEADBEEF.
  - ready_o=0 and busy=1 on the next edge.
  - After the sweep, r7=0 and r9 busy=0.
